fifo_wr_arbiter: RTL and testbench

//  Shares the write port of the 8-bit FIFO between N_REQ producers on the write clock domain.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 98 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Grants are combinational and never issued while the FIFO reports full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = N_REQ_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int IDX_W     = $clog2(N_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                    wr_clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    fifo_full,
    output logic [N_REQ-1:0]        gnt,
    output logic                    fifo_wr,
    output logic [DATA_W-1:0]       fifo_data,
    output logic [IDX_W-1:0]        owner,
    output logic                    busy
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_winner;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = '0;
        case (state_q)
            IDLE: begin
                if (pick_any && !fifo_full) begin
                    gnt[pick_winner] = 1'b1;
                    state_d          = BURST;
                    owner_d          = pick_winner;
                    burst_cnt_d      = CNT_W'(1);
                end
            end
            BURST: begin
                if (req[owner_q] && (burst_cnt_q < CNT_W'(MAX_BURST))) begin
                    // A full FIFO stalls the burst without releasing ownership.
                    if (!fifo_full) begin
                        gnt[owner_q] = 1'b1;
                        burst_cnt_d  = burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d     = IDLE;
                    rr_ptr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    burst_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Async reset must silence the write strobe immediately, not at the next edge.
        if (!reset_n) gnt = '0;
    end

    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            fifo_data = fifo_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
        end
    end

    assign fifo_wr = |gnt;
    assign owner   = owner_q;
    assign busy    = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: producer queues feed the arbiter, a byte-order scoreboard checks FIFO writes.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           wr_clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic           fifo_full;
    logic [N-1:0]   gnt;
    logic           fifo_wr;
    logic [W-1:0]   fifo_data;
    logic [1:0]     owner;
    logic           busy;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .wr_clk    (wr_clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_data  (req_data),
        .fifo_full (fifo_full),
        .gnt       (gnt),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic [7:0] pmem [N][32];
    int         ph [N];
    int         pt [N];
    exp_t       sbq [$];
    logic       trace [$];
    logic [N-1:0] gs;
    int         checks = 0;
    int         errors = 0;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]            = (ph[i] != pt[i]);
            req_data[i*W +: W] = req[i] ? pmem[i][ph[i]] : 8'h00;
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] b, input bit expect_wr);
        exp_t e;
        pmem[i][pt[i]] = b;
        pt[i]++;
        if (expect_wr) begin
            e.idx  = i;
            e.data = b;
            sbq.push_back(e);
        end
        drive_inputs();
    endtask

    // One clock: sample at negedge, score any write, then retire granted bytes after the edge.
    task automatic cycle();
        exp_t         e;
        logic [N-1:0] one;
        logic [N-1:0] eg;
        one = 1;
        @(negedge wr_clk);
        gs = gnt;
        trace.push_back(fifo_wr);
        if (fifo_full) begin
            checks++;
            if (fifo_wr !== 1'b0) begin
                errors++;
                $display("FAIL wr_while_full: fifo_wr=%b required 0", fifo_wr);
            end
        end
        if (fifo_wr === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: gnt=%b data=%h, no write required", gnt, fifo_data);
            end else begin
                e  = sbq.pop_front();
                eg = one << e.idx;
                if (gnt !== eg || fifo_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_order: gnt=%b data=%h required gnt=%b data=%h",
                             gnt, fifo_data, eg, e.data);
                end
            end
        end
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < N; i++) if (gs[i]) ph[i]++;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            ph[i] = 0;
            pt[i] = 0;
        end
        sbq.delete();
        drive_inputs();
        repeat (2) @(posedge wr_clk);
        #1;
        reset_n = 1'b1;
        trace.delete();
    endtask

    task automatic check_trace(input string name, input int n, input logic [31:0] expv);
        logic [31:0] tv;
        tv = '0;
        checks++;
        if (trace.size() < n) begin
            errors++;
            $display("FAIL %s: trace length %0d required %0d", name, trace.size(), n);
        end else begin
            for (int k = 0; k < n; k++) tv = {tv[30:0], trace[k]};
            if (tv !== expv) begin
                errors++;
                $display("FAIL %s: wr trace %b required %b", name, tv, expv);
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d bytes not written, required 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            ph[i] = 0;
            pt[i] = 0;
        end
        sbq.delete();
        push_byte(0, 8'h10, 1'b1);
        push_byte(1, 8'h11, 1'b1);
        push_byte(2, 8'h12, 1'b1);
        push_byte(3, 8'h13, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge wr_clk);
            checks++;
            if (gnt !== 4'b0000 || fifo_wr !== 1'b0 || fifo_data !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold: gnt=%b wr=%b data=%h busy=%b owner=%0d required all 0",
                         gnt, fifo_wr, fifo_data, busy, owner);
            end
            @(posedge wr_clk);
            #1;
        end
        reset_n = 1'b1;
        trace.delete();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_gnt: gnt=%b required 0001", gnt);
        end
        repeat (10) cycle();
        check_trace("reset_trace", 10, 32'b1010101000);
        check_sb_empty("reset_sb");
    endtask

    task automatic test_single_burst();
        do_reset();
        for (int b = 0; b < 6; b++) push_byte(2, 8'hAA + 8'(b), 1'b1);
        repeat (10) cycle();
        check_trace("single_trace", 10, 32'b1111011000);
        check_sb_empty("single_sb");
    endtask

    task automatic test_all_req();
        do_reset();
        for (int b = 0; b < 8; b++) push_byte(0, 8'h00 + 8'(b), 1'b0);
        for (int i = 1; i < N; i++)
            for (int b = 0; b < 4; b++) push_byte(i, 8'(16 * i + b), 1'b0);
        // Expected order: 0,1,2,3 then 0 again, four bytes each.
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 4; b++) sbq.push_back('{idx: i, data: 8'(16 * i + b)});
        for (int b = 4; b < 8; b++) sbq.push_back('{idx: 0, data: 8'(b)});
        repeat (27) cycle();
        check_trace("all_trace", 27, 32'b111101111011110111101111000);
        check_sb_empty("all_sb");
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int b = 0; b < 4; b++) push_byte(1, 8'h41 + 8'(b), 1'b1);
        repeat (2) cycle();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000 || fifo_wr !== 1'b0 || owner !== 2'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL full_stall: gnt=%b wr=%b owner=%0d busy=%b required 0000 0 1 1",
                         gnt, fifo_wr, owner, busy);
            end
            cycle();
        end
        fifo_full = 1'b0;
        repeat (4) cycle();
        check_trace("full_trace", 9, 32'b110001100);
        check_sb_empty("full_sb");
    endtask

    task automatic test_drop_wrap();
        do_reset();
        push_byte(2, 8'h52, 1'b1);
        repeat (3) cycle();
        trace.delete();
        push_byte(3, 8'h63, 1'b1);
        push_byte(0, 8'h50, 1'b1);
        #1;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL drop_first: gnt=%b required 1000", gnt);
        end
        cycle();
        #1;
        checks++;
        if (gnt !== 4'b0000 || owner !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_release: gnt=%b owner=%0d busy=%b required 0000 3 1", gnt, owner, busy);
        end
        cycle();
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL drop_wrap: gnt=%b required 0001", gnt);
        end
        repeat (2) cycle();
        check_trace("drop_trace", 4, 32'b1010);
        check_sb_empty("drop_sb");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int b = 0; b < 4; b++) push_byte(2, 8'h70 + 8'(b), 1'b0);
        sbq.push_back('{idx: 2, data: 8'h70});
        sbq.push_back('{idx: 2, data: 8'h71});
        repeat (2) cycle();
        push_byte(0, 8'h80, 1'b0);
        push_byte(1, 8'h81, 1'b0);
        push_byte(3, 8'h83, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || fifo_wr !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b gnt=%b wr=%b required 0 0000 0", busy, gnt, fifo_wr);
        end
        repeat (2) cycle();
        // Unwritten bytes stay with their producers; restart from requester 0.
        sbq.push_back('{idx: 0, data: 8'h80});
        sbq.push_back('{idx: 1, data: 8'h81});
        sbq.push_back('{idx: 2, data: 8'h72});
        sbq.push_back('{idx: 2, data: 8'h73});
        sbq.push_back('{idx: 3, data: 8'h83});
        reset_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_next: gnt=%b required 0001", gnt);
        end
        repeat (12) cycle();
        check_sb_empty("mid_sb");
    endtask

    initial begin
        reset_n   = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            ph[i] = 0;
            pt[i] = 0;
        end
        drive_inputs();
        test_reset();
        test_single_burst();
        test_all_req();
        test_full_stall();
        test_drop_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
